// File: rtl/quad_decoder_mc_pkg.sv
// Shared types and helpers for the multi-channel quadrature decoder:
// phase encoding, transition classification and saturating resize.
package quad_pkg;

    typedef logic [1:0] phase_t;  // {a, b}

    typedef enum logic [1:0] {
        TR_NONE,
        TR_UP,
        TR_DOWN,
        TR_ILLEGAL
    } trans_e;

    function automatic trans_e classify(input phase_t prev, input phase_t cur, input logic inv);
        phase_t diff;
        logic   up;
        trans_e res;
        diff = prev ^ cur;
        up   = (cur[1] ^ prev[0]) ^ inv;
        if (diff == 2'b00) begin
            res = TR_NONE;
        end else if (diff == 2'b11) begin
            res = TR_ILLEGAL;
        end else begin
            res = up ? TR_UP : TR_DOWN;
        end
        return res;
    endfunction

    // Clamp a signed value to the range of a w-bit two's complement number.
    function automatic logic signed [63:0] sat_resize(input logic signed [63:0] x, input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            res = hi;
        end else if (x < lo) begin
            res = lo;
        end else begin
            res = x;
        end
        return res;
    endfunction

endpackage

// File: rtl/quad_decoder_mc_channel.sv
// One encoder channel: synchroniser, glitch filter, x4 decode, position
// counter, sticky illegal-transition flag and velocity window reference.
module quad_channel
    import quad_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int VEL_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a_in,
    input  logic                    b_in,
    input  logic                    invert,
    input  logic                    clear,
    input  logic                    win_end,
    output logic signed [CNT_W-1:0] count,
    output logic signed [VEL_W-1:0] velocity,
    output logic                    error
);

    localparam int FC_W = $clog2(FILT_LEN + 1);
    localparam logic signed [CNT_W-1:0] ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0]  sync_a_q, sync_a_d, sync_b_q, sync_b_d;
    phase_t                  synced, filt_q, filt_d, prev_q, prev_d;
    logic [FC_W-1:0]         fcnt_q [2];
    logic [FC_W-1:0]         fcnt_d [2];
    trans_e                  ev_q, ev_d;
    logic signed [CNT_W-1:0] cnt_q, cnt_d, ref_q, ref_d, ref_base, delta;
    logic signed [VEL_W-1:0] vel_q, vel_d;
    logic                    err_q, err_d;

    always_comb begin
        sync_a_d = {sync_a_q[SYNC_STAGES-2:0], a_in};
        sync_b_d = {sync_b_q[SYNC_STAGES-2:0], b_in};
        synced   = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

        // Level only moves after FILT_LEN consecutive samples disagree with it.
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            fcnt_d[i] = '0;
            if (synced[i] != filt_q[i]) begin
                if (fcnt_q[i] == FC_W'(FILT_LEN - 1)) begin
                    filt_d[i] = synced[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + FC_W'(1);
                end
            end
        end

        prev_d = filt_q;
        ev_d   = classify(prev_q, filt_q, invert);

        cnt_d = cnt_q;
        err_d = err_q;
        case (ev_q)
            TR_UP:      cnt_d = cnt_q + ONE;
            TR_DOWN:    cnt_d = cnt_q - ONE;
            TR_ILLEGAL: err_d = 1'b1;
            default:    ;
        endcase
        if (clear) begin
            cnt_d = '0;
            err_d = 1'b0;
        end

        ref_base = clear ? '0 : ref_q;
        ref_d    = ref_base;
        delta    = cnt_d - ref_base;
        vel_d    = vel_q;
        if (win_end) begin
            vel_d = VEL_W'(sat_resize(64'(delta), VEL_W));
            ref_d = cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a_q  <= '0;
            sync_b_q  <= '0;
            filt_q    <= '0;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
            prev_q    <= '0;
            ev_q      <= TR_NONE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            ref_q     <= '0;
            vel_q     <= '0;
        end else begin
            sync_a_q  <= sync_a_d;
            sync_b_q  <= sync_b_d;
            filt_q    <= filt_d;
            fcnt_q[0] <= fcnt_d[0];
            fcnt_q[1] <= fcnt_d[1];
            prev_q    <= prev_d;
            ev_q      <= ev_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ref_q     <= ref_d;
            vel_q     <= vel_d;
        end
    end

    assign count    = cnt_q;
    assign velocity = vel_q;
    assign error    = err_q;

endmodule

// File: rtl/quad_decoder_mc.sv
// Multi-channel quadrature decoder top: per-channel decoders, shared
// velocity window timer, coherent snapshot latch and output packing.
module quad_decoder_mc
    import quad_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int CNT_W       = 32,
    parameter int VEL_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int VEL_PERIOD  = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         channel_A,
    input  logic [N_CH-1:0]         channel_B,
    input  logic [N_CH-1:0]         invert,
    input  logic [N_CH-1:0]         clear,
    input  logic                    snap_req,
    output logic [N_CH*CNT_W-1:0]   counter,
    output logic [N_CH*CNT_W-1:0]   snap_count,
    output logic                    snap_valid,
    output logic [N_CH*VEL_W-1:0]   velocity,
    output logic                    vel_valid,
    output logic [N_CH-1:0]         error
);

    localparam int WIN_W = $clog2(VEL_PERIOD);

    logic [WIN_W-1:0]        wcnt_q, wcnt_d;
    logic                    win_end;
    logic                    snap_req_q;
    logic                    snap_valid_q, snap_valid_d;
    logic                    vel_valid_q, vel_valid_d;
    logic [N_CH*CNT_W-1:0]   snap_count_q, snap_count_d;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        quad_channel #(
            .CNT_W      (CNT_W),
            .VEL_W      (VEL_W),
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_LEN   (FILT_LEN)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .a_in    (channel_A[ch]),
            .b_in    (channel_B[ch]),
            .invert  (invert[ch]),
            .clear   (clear[ch]),
            .win_end (win_end),
            .count   (counter[ch*CNT_W +: CNT_W]),
            .velocity(velocity[ch*VEL_W +: VEL_W]),
            .error   (error[ch])
        );
    end

    always_comb begin
        win_end      = (wcnt_q == WIN_W'(VEL_PERIOD - 1));
        wcnt_d       = win_end ? '0 : wcnt_q + WIN_W'(1);
        vel_valid_d  = win_end;
        // Request is registered so the latch sees every event up to its own edge.
        snap_valid_d = snap_req_q;
        snap_count_d = snap_req_q ? counter : snap_count_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt_q       <= '0;
            snap_req_q   <= 1'b0;
            snap_valid_q <= 1'b0;
            vel_valid_q  <= 1'b0;
            snap_count_q <= '0;
        end else begin
            wcnt_q       <= wcnt_d;
            snap_req_q   <= snap_req;
            snap_valid_q <= snap_valid_d;
            vel_valid_q  <= vel_valid_d;
            snap_count_q <= snap_count_d;
        end
    end

    assign snap_count = snap_count_q;
    assign snap_valid = snap_valid_q;
    assign vel_valid  = vel_valid_q;

endmodule

// File: tb/tb_quad_decoder_mc.sv
// Directed bench for quad_decoder_mc: rotation, glitch filtering, illegal
// jumps, counter wrap with snapshot, and windowed velocity with saturation.
module tb_quad_decoder_mc;

    localparam int N_CH = 2;
    localparam int CW   = 8;
    localparam int VW   = 16;
    localparam int VP   = 100;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N_CH-1:0] channel_A = '0;
    logic [N_CH-1:0] channel_B = '0;
    logic [N_CH-1:0] invert = '0;
    logic [N_CH-1:0] clear = '0;
    logic            snap_req = 1'b0;
    logic [N_CH*CW-1:0] counter, snap_count;
    logic               snap_valid, vel_valid;
    logic [N_CH*VW-1:0] velocity;
    logic [N_CH-1:0]    error;

    logic [CW-1:0] s_counter, s_snap;
    logic          s_snap_valid, s_vel_valid;
    logic [3:0]    s_velocity;
    logic [0:0]    s_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pos [N_CH];

    quad_decoder_mc #(
        .N_CH(N_CH), .CNT_W(CW), .VEL_W(VW), .SYNC_STAGES(2), .FILT_LEN(3), .VEL_PERIOD(VP)
    ) dut (
        .clk(clk), .reset(reset), .channel_A(channel_A), .channel_B(channel_B),
        .invert(invert), .clear(clear), .snap_req(snap_req), .counter(counter),
        .snap_count(snap_count), .snap_valid(snap_valid), .velocity(velocity),
        .vel_valid(vel_valid), .error(error)
    );

    // Narrow-velocity instance mirroring channel 0, used for saturation.
    quad_decoder_mc #(
        .N_CH(1), .CNT_W(CW), .VEL_W(4), .SYNC_STAGES(2), .FILT_LEN(3), .VEL_PERIOD(VP)
    ) dut_s (
        .clk(clk), .reset(reset), .channel_A(channel_A[0:0]), .channel_B(channel_B[0:0]),
        .invert(invert[0:0]), .clear(clear[0:0]), .snap_req(snap_req), .counter(s_counter),
        .snap_count(s_snap), .snap_valid(s_snap_valid), .velocity(s_velocity),
        .vel_valid(s_vel_valid), .error(s_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] phase_of(input int p);
        logic [1:0] r;
        case (p & 3)
            0:       r = 2'b00;
            1:       r = 2'b10;
            2:       r = 2'b11;
            default: r = 2'b01;
        endcase
        return r;
    endfunction

    function automatic int cnt_of(input int ch);
        logic signed [CW-1:0] v;
        v = counter[ch*CW +: CW];
        return int'(v);
    endfunction

    function automatic int vel_of(input int ch);
        logic signed [VW-1:0] v;
        v = velocity[ch*VW +: VW];
        return int'(v);
    endfunction

    task automatic drive(input int ch);
        logic [1:0] ph;
        ph = phase_of(pos[ch]);
        channel_A[ch] = ph[1];
        channel_B[ch] = ph[0];
    endtask

    task automatic step(input int ch, input int dir, input int hold);
        pos[ch] = (pos[ch] + dir) & 3;
        @(negedge clk);
        drive(ch);
        repeat (hold) @(posedge clk);
    endtask

    task automatic apply_reset;
        @(negedge clk);
        reset = 1'b0;
        channel_A = '0;
        channel_B = '0;
        invert = '0;
        clear = '0;
        snap_req = 1'b0;
        pos[0] = 0;
        pos[1] = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #1;
        checks += 6;
        if (counter !== '0) begin errors++; $display("FAIL reset_counter got %h want 0", counter); end
        if (snap_count !== '0) begin errors++; $display("FAIL reset_snap got %h want 0", snap_count); end
        if (velocity !== '0) begin errors++; $display("FAIL reset_velocity got %h want 0", velocity); end
        if (error !== '0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
        if (snap_valid !== 1'b0) begin errors++; $display("FAIL reset_snap_valid got %b want 0", snap_valid); end
        if (vel_valid !== 1'b0) begin errors++; $display("FAIL reset_vel_valid got %b want 0", vel_valid); end
        apply_reset();
    endtask

    task automatic test_forward;
        apply_reset();
        for (int i = 0; i < 32; i++) step(0, 1, 20);
        repeat (10) @(posedge clk);
        #1;
        checks += 3;
        if (cnt_of(0) !== 32) begin errors++; $display("FAIL fwd_cnt0 got %0d want 32", cnt_of(0)); end
        if (cnt_of(1) !== 0) begin errors++; $display("FAIL fwd_cnt1 got %0d want 0", cnt_of(1)); end
        if (error !== 2'b00) begin errors++; $display("FAIL fwd_error got %b want 00", error); end
    endtask

    task automatic test_reverse;
        apply_reset();
        invert[0] = 1'b1;
        for (int i = 0; i < 16; i++) step(0, -1, 20);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (cnt_of(0) !== 16) begin errors++; $display("FAIL rev_inv_cnt got %0d want 16", cnt_of(0)); end
        apply_reset();
        for (int i = 0; i < 16; i++) step(0, -1, 20);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (cnt_of(0) !== -16) begin errors++; $display("FAIL rev_cnt got %0d want -16", cnt_of(0)); end
    endtask

    task automatic test_glitch;
        apply_reset();
        @(negedge clk);
        channel_A[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        channel_A[0] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checks += 2;
        if (cnt_of(0) !== 0) begin errors++; $display("FAIL glitch_cnt got %0d want 0", cnt_of(0)); end
        if (error !== 2'b00) begin errors++; $display("FAIL glitch_error got %b want 00", error); end
        pos[0] = 1;
        @(negedge clk);
        drive(0);
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (cnt_of(0) !== 0) begin errors++; $display("FAIL latency_early got %0d want 0", cnt_of(0)); end
        @(posedge clk);
        #1;
        checks++;
        if (cnt_of(0) !== 1) begin errors++; $display("FAIL latency_edge got %0d want 1", cnt_of(0)); end
    endtask

    task automatic test_illegal;
        apply_reset();
        step(0, 1, 6);
        step(0, 1, 6);
        @(negedge clk);
        channel_A[0] = 1'b0;
        channel_B[0] = 1'b0;
        pos[0] = 0;
        repeat (30) @(posedge clk);
        #1;
        checks += 3;
        if (error !== 2'b01) begin errors++; $display("FAIL illegal_error got %b want 01", error); end
        if (cnt_of(0) !== 2) begin errors++; $display("FAIL illegal_cnt got %0d want 2", cnt_of(0)); end
        if (s_error !== 1'b1) begin errors++; $display("FAIL illegal_error_s got %b want 1", s_error); end
        @(negedge clk);
        clear[0] = 1'b1;
        @(negedge clk);
        clear[0] = 1'b0;
        #1;
        checks += 2;
        if (cnt_of(0) !== 0) begin errors++; $display("FAIL clear_cnt got %0d want 0", cnt_of(0)); end
        if (error !== 2'b00) begin errors++; $display("FAIL clear_error got %b want 00", error); end
    endtask

    task automatic test_wrap_snap;
        apply_reset();
        for (int i = 0; i < 127; i++) step(0, 1, 4);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (cnt_of(0) !== 127) begin errors++; $display("FAIL preload_cnt got %0d want 127", cnt_of(0)); end
        pos[0] = (pos[0] + 1) & 3;
        @(negedge clk);
        drive(0);
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        snap_req = 1'b1;
        @(posedge clk);
        #1;
        snap_req = 1'b0;
        checks += 2;
        if (cnt_of(0) !== -128) begin errors++; $display("FAIL wrap_cnt got %0d want -128", cnt_of(0)); end
        if (snap_valid !== 1'b0) begin errors++; $display("FAIL snap_valid_early got %b want 0", snap_valid); end
        @(posedge clk);
        #1;
        checks += 3;
        if (snap_count[7:0] !== 8'h80) begin errors++; $display("FAIL snap_cnt0 got %h want 80", snap_count[7:0]); end
        if (snap_count[15:8] !== 8'h00) begin errors++; $display("FAIL snap_cnt1 got %h want 00", snap_count[15:8]); end
        if (snap_valid !== 1'b1) begin errors++; $display("FAIL snap_valid got %b want 1", snap_valid); end
        @(posedge clk);
        #1;
        checks += 2;
        if (snap_valid !== 1'b0) begin errors++; $display("FAIL snap_valid_pulse got %b want 0", snap_valid); end
        if (snap_count[7:0] !== 8'h80) begin errors++; $display("FAIL snap_hold got %h want 80", snap_count[7:0]); end
        step(0, -1, 12);
        #1;
        checks++;
        if (cnt_of(0) !== 127) begin errors++; $display("FAIL wrap_down got %0d want 127", cnt_of(0)); end
    endtask

    task automatic wait_vel(output bit found);
        found = 1'b0;
        for (int i = 0; i < 250 && !found; i++) begin
            @(posedge clk);
            #1;
            if (vel_valid === 1'b1) found = 1'b1;
        end
        if (!found) begin
            errors++;
            checks++;
            $display("FAIL vel_valid_timeout got 0 want 1");
        end
    endtask

    task automatic test_velocity;
        bit found;
        int t1;
        apply_reset();
        for (int i = 0; i < 10; i++) step(0, 1, 4);
        wait_vel(found);
        t1 = cyc;
        checks += 3;
        if (vel_of(0) !== 10) begin errors++; $display("FAIL vel_w1 got %0d want 10", vel_of(0)); end
        if (vel_of(1) !== 0) begin errors++; $display("FAIL vel_w1_ch1 got %0d want 0", vel_of(1)); end
        if ($signed(s_velocity) !== 4'sd7) begin errors++; $display("FAIL vel_sat got %0d want 7", $signed(s_velocity)); end
        for (int i = 0; i < 5; i++) step(0, -1, 4);
        wait_vel(found);
        checks += 3;
        if (vel_of(0) !== -5) begin errors++; $display("FAIL vel_w2 got %0d want -5", vel_of(0)); end
        if ($signed(s_velocity) !== -4'sd5) begin errors++; $display("FAIL vel_w2_s got %0d want -5", $signed(s_velocity)); end
        if (cyc - t1 !== VP) begin errors++; $display("FAIL vel_period got %0d want %0d", cyc - t1, VP); end
        @(posedge clk);
        #1;
        checks++;
        if (vel_valid !== 1'b0) begin errors++; $display("FAIL vel_valid_pulse got %b want 0", vel_valid); end
        repeat (30) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks += 3;
        if (counter !== '0) begin errors++; $display("FAIL async_counter got %h want 0", counter); end
        if (velocity !== '0) begin errors++; $display("FAIL async_velocity got %h want 0", velocity); end
        if (s_counter !== '0) begin errors++; $display("FAIL async_counter_s got %h want 0", s_counter); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        pos[0] = 0;
        pos[1] = 0;
        test_reset();
        test_forward();
        test_reverse();
        test_glitch();
        test_illegal();
        test_wrap_snap();
        test_velocity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_decoder_mc.md
Name: quad_decoder_mc

Overview:
Multi-channel, parametrised quadrature decoder for the Minibot wheel and auxiliary encoders. Each channel has:
- an input synchroniser and glitch filter;
- a ×4 Gray-code decode with illegal-transition detection;
- a wrapping signed position counter.

A global snapshot strobe latches every channel's position coherently. A free-running window produces per-channel velocity (count delta per window). The block sits between the encoder pins and the SPI/register interface.

Parameters:
N_CH, 2, number of encoder channels (1..8)
CNT_W, 32, position counter width in bits (two's complement)
VEL_W, 16, velocity output width in bits (two's complement, saturating)
SYNC_STAGES, 2, synchroniser flops per input (>=2)
FILT_LEN, 3, consecutive identical samples required before the filtered level changes (>=1)
VEL_PERIOD, 50000, clock cycles per velocity window (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
channel_A  in  N_CH  raw encoder A inputs, one bit per channel
channel_B  in  N_CH  raw encoder B inputs
invert  in  N_CH  per-channel direction swap (1 = negate count direction)
clear  in  N_CH  per-channel synchronous clear of counter and error flag
snap_req  in  1  single-cycle snapshot request
counter  out  N_CH*CNT_W  live positions, channel i at [i*CNT_W +: CNT_W]
snap_count  out  N_CH*CNT_W  latched positions
snap_valid  out  1  one-cycle pulse when snap_count is updated
velocity  out  N_CH*VEL_W  position delta over the last completed window
vel_valid  out  1  one-cycle pulse when velocity is updated
error  out  N_CH  sticky illegal-transition flag

Behaviour:
- Reset (reset=0, asynchronous) clears all outputs to 0:
  - counter, snap_count, velocity, error, snap_valid, vel_valid;
  - all synchroniser, filter, window and previous-state registers are also 0.
  - Deassertion is taken synchronously on clk.
- Synchroniser: SYNC_STAGES-flop chain per A and B input.
- Filter: per input, a counter of consecutive samples differing from the filtered level.
  - The filtered level takes the synced value once FILT_LEN consecutive differing samples are seen.
  - Any sample equal to the filtered level resets that counter to 0.
  - Pulses shorter than FILT_LEN cycles are rejected.
- Decode on the filtered pair (a, b) against the previous pair (a_p, b_p):
  - Exactly one of a, b changed → count event. Direction is up if a ^ b_p = 1, down otherwise. invert=1 swaps direction.
  - Both changed → illegal. No count; error[ch] is set and stays set until clear[ch] or reset.
  - Neither changed → no action.
- Latency: an input edge sampled at clk edge k changes counter at edge k + SYNC_STAGES + FILT_LEN + 1 (6 with defaults).
- Counter arithmetic: modulo 2^CNT_W. Max + 1 wraps to min; min − 1 wraps to max. No flag on wrap.
- clear[ch] in the same cycle as a count event: clear wins, so the counter becomes 0 and the event is lost. The decode history is not cleared.
- Snapshot:
  - snap_req=1 at edge k → snap_count holds counter values as of the end of cycle k (including any event at edge k) at edge k+1, with snap_valid=1 for that one cycle.
  - snap_req held high snaps every cycle.
- Velocity window:
  - A counter runs 0..VEL_PERIOD−1. On reaching VEL_PERIOD−1, at the next edge, for each channel: velocity = counter_new − counter_at_previous_window_end.
  - The subtraction is modular in CNT_W, so a counter wrap gives the correct delta. The result saturates to the VEL_W range.
  - counter_at_previous_window_end is reloaded and vel_valid pulses for one cycle.
  - clear[ch] inside a window also zeroes that channel's window reference, so the next velocity equals the counts since the clear.
- The first window after reset reports its delta relative to 0.

Decomposition:
- quad_pkg:
  - typedef for the 2-bit phase {a,b};
  - enum for the transition class (NONE, UP, DOWN, ILLEGAL);
  - function classify(prev, cur, invert);
  - saturating resize function for velocity.
- Sub-module quad_channel, instantiated N_CH times in a generate loop. It holds the synchroniser, filter, decode, counter, error flag and window reference. Parameters are CNT_W, VEL_W, SYNC_STAGES and FILT_LEN.
- The top level owns the window counter, snap logic and output packing.

Test Plan:
- Forward rotation on ch0: 8 full cycles of A-leading-B, 20 clk per phase → counter[0]=32, counter[1]=0, error=0.
- Reverse rotation with invert[0]=1: 4 cycles of B-leading-A → counter[0]=+16. With invert=0 the same stimulus gives −16.
- Glitch rejection: 2-cycle pulse on A (FILT_LEN=3) → counter unchanged. A 3-cycle-stable edge increments counter exactly 6 cycles after the input edge.
- Illegal jump: A and B toggled in the same cycle from 00 → error[0]=1 and no count. clear[0] at a later edge → counter[0]=0 and error[0]=0 one cycle later.
- Wrap and snapshot with CNT_W=8:
  - preload to 127 via 127 up events, then one more up → counter=−128;
  - snap_req in the cycle of that event → snap_count=−128 and snap_valid high for exactly 1 cycle.
- Velocity with VEL_PERIOD=100: 10 up events in window 1, then 5 down events in window 2 → velocity=10, then −5, with vel_valid pulses exactly 100 cycles apart. An async reset mid-window → all outputs 0 immediately.
